// File: rtl/settings_bus_pkg.sv
// Shared constants and readback-map helpers for the settings bus responder.
// The readback map is user registers, then external status words, then the miss counter.
package settings_bus_pkg;

    localparam int SR_AWIDTH_DEF = 8;
    localparam int SR_DWIDTH_DEF = 32;
    localparam int RB_AWIDTH_DEF = 8;
    localparam int RB_DWIDTH_DEF = 64;

    localparam int MISS_CNT_W = 16;

    localparam int RB_USER_OFS = 0;

    function automatic int rb_ext_ofs(input int num_regs);
        return num_regs;
    endfunction

    function automatic int rb_miss_ofs(input int num_regs);
        return 2 * num_regs;
    endfunction

    // Width of a register index; a single register still needs one bit.
    function automatic int idx_width(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/sb_readback_pipe.sv
// Fixed-latency delay line of {valid, data} for readback words.
// Accepts one entry per cycle; the last stage drives the readback outputs directly.
module sb_readback_pipe #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/settings_bus_responder.sv
// Responder end of the settings/readback bus: decodes writes into a register bank,
// counts misses, and answers every strobe with one readback word after RB_LATENCY cycles.
module settings_bus_responder
    import settings_bus_pkg::*;
#(
    parameter int SR_AWIDTH  = SR_AWIDTH_DEF,
    parameter int SR_DWIDTH  = SR_DWIDTH_DEF,
    parameter int RB_AWIDTH  = RB_AWIDTH_DEF,
    parameter int RB_DWIDTH  = RB_DWIDTH_DEF,
    parameter int BASE       = 0,
    parameter int NUM_REGS   = 8,
    parameter int RB_LATENCY = 1,
    parameter logic [SR_DWIDTH-1:0] RESET_VAL = '0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          set_stb,
    input  logic [SR_AWIDTH-1:0]          set_addr,
    input  logic [SR_DWIDTH-1:0]          set_data,
    input  logic [RB_AWIDTH-1:0]          rb_addr,
    output logic                          rb_stb,
    output logic [RB_DWIDTH-1:0]          rb_data,
    output logic [NUM_REGS*SR_DWIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]           reg_changed,
    input  logic [NUM_REGS*RB_DWIDTH-1:0] rb_ext
);

    // Bus protocol: set_stb is a one-cycle transaction qualifier with no ready;
    // each strobe yields exactly one rb_stb pulse, in order, and rb_data is 0 otherwise.

    localparam int IDX_W = idx_width(NUM_REGS);
    localparam int CMP_W = SR_AWIDTH + 1;
    localparam int RBA_W = RB_AWIDTH + 1;

    localparam logic [CMP_W-1:0]      BASE_LO  = CMP_W'(BASE);
    localparam logic [CMP_W-1:0]      BASE_HI  = CMP_W'(BASE + NUM_REGS);
    localparam logic [RBA_W-1:0]      USER_LO  = RBA_W'(RB_USER_OFS);
    localparam logic [RBA_W-1:0]      EXT_LO   = RBA_W'(rb_ext_ofs(NUM_REGS));
    localparam logic [RBA_W-1:0]      MISS_A   = RBA_W'(rb_miss_ofs(NUM_REGS));
    localparam logic [MISS_CNT_W-1:0] MISS_MAX = '1;

    if (RB_DWIDTH < SR_DWIDTH) begin : g_bad_rb_width
        $error("settings_bus_responder: RB_DWIDTH must be >= SR_DWIDTH");
    end
    if (NUM_REGS < 1 || NUM_REGS > 64) begin : g_bad_num_regs
        $error("settings_bus_responder: NUM_REGS must be in 1..64");
    end
    if (RB_LATENCY < 1 || RB_LATENCY > 4) begin : g_bad_latency
        $error("settings_bus_responder: RB_LATENCY must be in 1..4");
    end

    logic [CMP_W-1:0]      wr_addr;
    logic [IDX_W-1:0]      wr_idx;
    logic                  hit;
    logic [NUM_REGS-1:0]   wr_en;
    logic [SR_DWIDTH-1:0]  regs [NUM_REGS];
    logic [MISS_CNT_W-1:0] miss_cnt;
    logic [MISS_CNT_W-1:0] miss_next;

    logic [RBA_W-1:0]      rd_addr;
    logic [IDX_W-1:0]      user_idx;
    logic [IDX_W-1:0]      ext_idx;
    logic [SR_DWIDTH-1:0]  user_word;
    logic [RB_DWIDTH-1:0]  rb_word;
    logic [RB_DWIDTH-1:0]  pipe_data;

    // One extra address bit keeps BASE+NUM_REGS from wrapping at the top of the map.
    assign wr_addr = {1'b0, set_addr};
    assign hit     = set_stb && (wr_addr >= BASE_LO) && (wr_addr < BASE_HI);
    assign wr_idx  = IDX_W'(wr_addr - BASE_LO);

    always_comb begin
        wr_en = '0;
        if (hit) begin
            wr_en[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
            reg_changed <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en[i]) begin
                    regs[i] <= set_data;
                end
            end
            reg_changed <= wr_en;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
        assign reg_out[i*SR_DWIDTH +: SR_DWIDTH] = regs[i];
    end

    always_comb begin
        miss_next = miss_cnt;
        if (set_stb && !hit && (miss_cnt != MISS_MAX)) begin
            miss_next = miss_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            miss_cnt <= '0;
        end else begin
            miss_cnt <= miss_next;
        end
    end

    assign rd_addr  = {1'b0, rb_addr};
    assign user_idx = IDX_W'(rd_addr - USER_LO);
    assign ext_idx  = IDX_W'(rd_addr - EXT_LO);

    // Readback shows post-transaction state: bypass the register being written now.
    assign user_word = (hit && (wr_idx == user_idx)) ? set_data : regs[user_idx];

    always_comb begin
        rb_word = '0;
        if (rd_addr < EXT_LO) begin
            rb_word = RB_DWIDTH'(user_word);
        end else if (rd_addr < MISS_A) begin
            rb_word = rb_ext[ext_idx*RB_DWIDTH +: RB_DWIDTH];
        end else if (rd_addr == MISS_A) begin
            rb_word = RB_DWIDTH'(miss_next);
        end
    end

    assign pipe_data = set_stb ? rb_word : '0;

    sb_readback_pipe #(
        .DEPTH (RB_LATENCY),
        .WIDTH (RB_DWIDTH)
    ) u_rb_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (set_stb),
        .in_data   (pipe_data),
        .out_valid (rb_stb),
        .out_data  (rb_data)
    );

endmodule

// File: tb/tb_settings_bus_responder.sv
// Directed bench for settings_bus_responder at readback latencies 1, 2 and 3 sharing one stimulus stream.
// A reference model predicts register state and readback words; per-latency monitors check arrival data and cycle.
module tb_settings_bus_responder;

    localparam int NR   = 8;
    localparam int BASE = 16;
    localparam int SDW  = 32;
    localparam int RDW  = 64;
    localparam int NDUT = 3;
    localparam logic [SDW-1:0] RST_VAL = 32'h0000_5A5A;

    logic              clk      = 1'b0;
    logic              reset_n  = 1'b0;
    logic              set_stb  = 1'b0;
    logic [7:0]        set_addr = '0;
    logic [SDW-1:0]    set_data = '0;
    logic [7:0]        rb_addr  = '0;
    logic [NR*RDW-1:0] rb_ext   = '0;

    logic              rb_stb_v      [NDUT];
    logic [RDW-1:0]    rb_data_v     [NDUT];
    logic [NR*SDW-1:0] reg_out_v     [NDUT];
    logic [NR-1:0]     reg_changed_v [NDUT];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        settings_bus_responder #(
            .BASE       (BASE),
            .NUM_REGS   (NR),
            .RB_LATENCY (g + 1),
            .RESET_VAL  (RST_VAL)
        ) u_dut (
            .clk         (clk),
            .reset_n     (reset_n),
            .set_stb     (set_stb),
            .set_addr    (set_addr),
            .set_data    (set_data),
            .rb_addr     (rb_addr),
            .rb_stb      (rb_stb_v[g]),
            .rb_data     (rb_data_v[g]),
            .reg_out     (reg_out_v[g]),
            .reg_changed (reg_changed_v[g]),
            .rb_ext      (rb_ext)
        );
    end

    // ---------------- scoreboard ----------------
    logic [RDW-1:0] exp_q [NDUT][$];
    int             due_q [NDUT][$];
    int             n_checks = 0;
    int             n_fail   = 0;

    logic [SDW-1:0] mdl [NR];
    logic [15:0]    mdl_miss;
    logic [RDW-1:0] ext_words [NR];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR*SDW-1:0] model_vec();
        logic [NR*SDW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*SDW +: SDW] = mdl[i];
        return v;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_mon
        always @(negedge clk) begin
            if (rb_stb_v[g]) begin
                if (exp_q[g].size() == 0) begin
                    check($sformatf("rb_unexpected_lat%0d", g + 1), rb_stb_v[g], 0);
                end else begin
                    check($sformatf("rb_data_lat%0d", g + 1), rb_data_v[g], exp_q[g].pop_front());
                    check($sformatf("rb_cycle_lat%0d", g + 1), cyc, due_q[g].pop_front());
                end
            end else begin
                check($sformatf("rb_idle_zero_lat%0d", g + 1), rb_data_v[g], 0);
                if (due_q[g].size() != 0 && due_q[g][0] <= cyc) begin
                    check($sformatf("rb_missing_lat%0d", g + 1), rb_stb_v[g], 1);
                    void'(exp_q[g].pop_front());
                    void'(due_q[g].pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic [7:0] a, input logic [SDW-1:0] d, input logic [7:0] ra);
        logic [RDW-1:0] exp_rb;
        logic [NR-1:0]  exp_chg;
        exp_chg = '0;
        if (a >= BASE && a < BASE + NR) begin
            mdl[a - BASE]     = d;
            exp_chg[a - BASE] = 1'b1;
        end else if (mdl_miss != 16'hFFFF) begin
            mdl_miss = mdl_miss + 16'd1;
        end
        if (ra < NR)            exp_rb = {32'h0, mdl[ra]};
        else if (ra < 2 * NR)   exp_rb = ext_words[ra - NR];
        else if (ra == 2 * NR)  exp_rb = {48'h0, mdl_miss};
        else                    exp_rb = '0;

        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        rb_addr  = ra;
        for (int g = 0; g < NDUT; g++) begin
            exp_q[g].push_back(exp_rb);
            due_q[g].push_back(cyc + g + 1);
        end
        step(1);
        set_stb = 1'b0;
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("reg_out_a%0d", a), reg_out_v[g], model_vec());
            check($sformatf("reg_changed_a%0d", a), reg_changed_v[g], exp_chg);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < NR; i++) mdl[i] = RST_VAL;
        mdl_miss = '0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_model();
        for (int i = 0; i < NR; i++) begin
            ext_words[i] = 64'h1122_3344_5566_7788 ^ {8{8'(i ^ 1)}};
            rb_ext[i*RDW +: RDW] = ext_words[i];
        end

        step(3);
        for (int g = 0; g < NDUT; g++) begin
            check("reset_reg_out", reg_out_v[g], model_vec());
            check("reset_reg_changed", reg_changed_v[g], 0);
            check("reset_rb_stb", rb_stb_v[g], 0);
            check("reset_rb_data", rb_data_v[g], 0);
        end
        reset_n = 1'b1;
        step(2);

        // basic write with readback of the same register, then single-cycle pulse
        txn(8'd18, 32'hA5A5_0001, 8'd2);
        step(1);
        for (int g = 0; g < NDUT; g++) check("reg_changed_single_pulse", reg_changed_v[g], 0);

        // bypass: readback returns the value written in the same strobe
        txn(8'd19, 32'h1111_2222, 8'd0);
        txn(8'd19, 32'hDEAD_BEEF, 8'd3);
        txn(8'd16, 32'h0000_0016, 8'd7);
        txn(8'd23, 32'hCAFE_0023, 8'd7);
        step(4);

        // misses just below and just above the window
        txn(8'd15, 32'hBAD0_000F, 8'd16);
        txn(8'd24, 32'hBAD0_0018, 8'd16);
        step(4);

        // external words, edge of the external range, unmapped addresses
        txn(8'd20, 32'h0000_0014, 8'd9);
        txn(8'd21, 32'h0000_0015, 8'd15);
        txn(8'd0,  32'h0000_0000, 8'd200);
        txn(8'd22, 32'h0000_0016, 8'd17);
        step(4);

        // back-to-back strobes with random data
        for (int i = 0; i < 5; i++) begin
            txn(8'(BASE + $urandom_range(0, NR - 1)), $urandom, 8'(i));
        end
        step(6);

        // saturated miss counter stays at 0xFFFF and still answers
        force g_dut[0].u_dut.miss_cnt = 16'hFFFF;
        force g_dut[1].u_dut.miss_cnt = 16'hFFFF;
        force g_dut[2].u_dut.miss_cnt = 16'hFFFF;
        mdl_miss = 16'hFFFF;
        txn(8'd5,   32'h0000_0005, 8'd16);
        txn(8'd250, 32'h0000_00FA, 8'd16);
        step(5);
        release g_dut[0].u_dut.miss_cnt;
        release g_dut[1].u_dut.miss_cnt;
        release g_dut[2].u_dut.miss_cnt;

        // reset one cycle after a strobe: the in-flight answer is dropped
        txn(8'd21, 32'h1234_5678, 8'd5);
        reset_n = 1'b0;
        for (int g = 0; g < NDUT; g++) begin
            exp_q[g].delete();
            due_q[g].delete();
        end
        reset_model();
        step(1);
        for (int g = 0; g < NDUT; g++) begin
            check("midreset_reg_out", reg_out_v[g], model_vec());
            check("midreset_rb_stb", rb_stb_v[g], 0);
        end
        step(3);
        reset_n = 1'b1;
        step(5);

        // normal operation after release, miss counter restarted
        txn(8'd22, 32'h0BAD_F00D, 8'd6);
        txn(8'd1,  32'h0000_0001, 8'd16);

        for (int k = 0; k < 20; k++) begin
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
            step(1);
        end
        for (int g = 0; g < NDUT; g++) check($sformatf("drain_lat%0d", g + 1), exp_q[g].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
